// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Two requesters share a single interval counter. An idle block grants the
//   counter to one requester, using a round-robin pointer when both ask at
//   once. The owner's interval length is latched at grant time. The counter
//   runs from 0 up to that length, then a one-cycle done pulse goes to the
//   owner. If the owner drops its request while the counter is running, the
//   interval is aborted and no done pulse is produced.
//
// Ports
//   clk    - single clock; all state updates on its rising edge
//   reset  - asynchronous, active-high reset
//   req    - req[i] high: requester i wants a timed interval
//   len0   - interval length requested by requester 0 (WIDTH bits)
//   len1   - interval length requested by requester 1 (WIDTH bits)
//   gnt    - registered one-hot grant; high while the owner's counter runs
//   busy   - high in the RUN and DONE states
//   cnt    - shared interval counter value (WIDTH bits)
//   done   - done[i] is a one-cycle completion pulse for requester i
module counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] cnt,
    output logic [1:0]       done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic             owner;  // index of the requester that holds the counter
    logic             ptr;    // round-robin pointer, used only on contention
    logic [WIDTH-1:0] len_q;  // length latched at grant time
    logic             pick;   // requester that would be granted from IDLE

    // Only a tie between the two requesters consults the pointer.
    always_comb begin
        pick = ptr;
        if (req == 2'b01) begin
            pick = 1'b0;
        end else if (req == 2'b10) begin
            pick = 1'b1;
        end
    end

    assign busy = (state == RUN) || (state == DONE);

    // NOTE: every register here is assigned with <= so that all of them
    // sample the same pre-edge values. Blocking assignments would let later
    // statements see values that were already updated in this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 2'b00;
            done  <= 2'b00;
            cnt   <= '0;
            ptr   <= 1'b0;
            owner <= 1'b0;
            len_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 2'b00;
                    if (req != 2'b00) begin
                        state <= RUN;
                        owner <= pick;
                        gnt   <= pick ? 2'b10 : 2'b01;
                        cnt   <= '0;
                        len_q <= pick ? len1 : len0;
                    end else begin
                        gnt <= 2'b00;
                    end
                end
                RUN: begin
                    if (!req[owner]) begin
                        // Abort: the counter keeps its value and there is no done pulse.
                        state <= IDLE;
                        gnt   <= 2'b00;
                        ptr   <= ~owner;
                    end else if (cnt != len_q) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        // The counter holds at len_q here, so it never wraps.
                        state <= DONE;
                        gnt   <= 2'b00;
                        done  <= owner ? 2'b10 : 2'b01;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 2'b00;
                    ptr   <= ~owner;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                    done  <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Drives directed scenarios and then randomized requests, lengths and
//   resets into counter_sequencer. Each cycle's outputs are compared against
//   an interval-level reference model. That model tracks when the current
//   interval started and how long it is. From those two numbers it derives
//   gnt, busy, cnt and done arithmetically.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] gnt;
    logic       busy;
    logic [3:0] cnt;
    logic [1:0] done;

    counter_sequencer #(.WIDTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .len0 (len0),
        .len1 (len1),
        .gnt  (gnt),
        .busy (busy),
        .cnt  (cnt),
        .done (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one interval = (owner, start cycle, length).
    // Cycle offset e = t - start: e in [0, len] is counting and e = len+1 is
    // the done cycle. When no interval is active, cnt shows its last value.
    bit m_active;
    int m_owner;
    int m_start;
    int m_len;
    int m_cnt;
    int m_ptr;
    int t;

    task automatic model_reset();
        m_active = 0;
        m_owner  = 0;
        m_start  = 0;
        m_len    = 0;
        m_cnt    = 0;
        m_ptr    = 0;
        t        = 0;
    endtask

    // Applies one rising edge, using the inputs that were present before it.
    task automatic model_edge();
        int e_prev;
        if (reset) begin
            model_reset();
            return;
        end
        t++;
        if (!m_active) begin
            if (req != 2'b00) begin
                if (req == 2'b11) m_owner = m_ptr;
                else              m_owner = req[1] ? 1 : 0;
                m_start  = t;
                m_len    = (m_owner == 1) ? int'(len1) : int'(len0);
                m_active = 1;
            end
        end else begin
            e_prev = t - 1 - m_start;
            if (e_prev <= m_len) begin
                if (!req[m_owner]) begin
                    m_active = 0;
                    m_cnt    = e_prev;
                    m_ptr    = 1 - m_owner;
                end
            end else begin
                m_active = 0;
                m_cnt    = m_len;
                m_ptr    = 1 - m_owner;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [1:0] e_gnt, e_done, oh;
        logic       e_busy;
        int         e_cnt;
        int         e;
        e_gnt  = 2'b00;
        e_done = 2'b00;
        e_busy = 1'b0;
        e_cnt  = m_cnt;
        oh     = (m_owner == 1) ? 2'b10 : 2'b01;
        if (m_active) begin
            e      = t - m_start;
            e_busy = 1'b1;
            if (e <= m_len) begin
                e_gnt = oh;
                e_cnt = e;
            end else begin
                e_done = oh;
                e_cnt  = m_len;
            end
        end
        check("gnt",  32'(gnt),  32'(e_gnt));
        check("busy", 32'(busy), 32'(e_busy));
        check("cnt",  32'(cnt),  32'(e_cnt));
        check("done", 32'(done), 32'(e_done));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    // Asserts reset between clock edges and checks that the outputs clear
    // before the next edge arrives. Reset is then held over one edge and
    // released between edges.
    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        check("rst_gnt",  32'(gnt),  32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt",  32'(cnt),  32'd0);
        check("rst_done", 32'(done), 32'd0);
        model_reset();
        step();
        #2 reset = 1'b0;
    endtask

    logic [1:0] done_seq[$];

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        len0  = 4'd0;
        len1  = 4'd0;
        model_reset();
        step();
        step();
        #2 reset = 1'b0;

        // Single request with len0 = 3: four counting cycles, then done = 01.
        req  = 2'b01;
        len0 = 4'd3;
        step();
        repeat (4) step();
        check("single_done", 32'(done), 32'd1);
        check("single_cnt", 32'(cnt), 32'd3);
        req = 2'b00;
        repeat (2) step();

        // The length is latched: changing len0 mid-run must not move the end point.
        req  = 2'b01;
        len0 = 4'd3;
        step();
        len0 = 4'd9;
        repeat (4) step();
        check("latch_done", 32'(done), 32'd1);
        check("latch_cnt", 32'(cnt), 32'd3);
        req = 2'b00;
        repeat (2) step();

        // Contention after reset: requesters are served 0, 1, 0.
        async_reset_pulse();
        req  = 2'b11;
        len0 = 4'd1;
        len1 = 4'd2;
        repeat (16) begin
            step();
            if (done != 2'b00) done_seq.push_back(done);
        end
        check("rr_count", 32'(done_seq.size() >= 3), 32'd1);
        if (done_seq.size() >= 3) begin
            check("rr_first",  32'(done_seq[0]), 32'd1);
            check("rr_second", 32'(done_seq[1]), 32'd2);
            check("rr_third",  32'(done_seq[2]), 32'd1);
        end
        req = 2'b00;
        repeat (6) step();

        // Boundaries: len1 = 0, then len0 = 15 counting to all-ones.
        req  = 2'b10;
        len1 = 4'd0;
        repeat (3) step();
        req = 2'b00;
        step();
        req  = 2'b01;
        len0 = 4'd15;
        repeat (17) step();
        check("max_done", 32'(done), 32'd1);
        check("max_cnt", 32'(cnt), 32'd15);
        req = 2'b00;
        repeat (2) step();

        // Abort at cnt = 4. The pointer then moves to requester 1, so a tie goes to 1.
        async_reset_pulse();
        req  = 2'b01;
        len0 = 4'd8;
        repeat (5) step();
        check("abort_at", 32'(cnt), 32'd4);
        req = 2'b00;
        step();
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        req = 2'b11;
        step();
        check("abort_ptr", 32'(gnt), 32'd2);
        req = 2'b00;
        repeat (3) step();

        // Asynchronous reset mid-run at cnt = 5, then a normal re-grant.
        req  = 2'b01;
        len0 = 4'd9;
        repeat (6) step();
        check("pre_rst_cnt", 32'(cnt), 32'd5);
        async_reset_pulse();
        len0 = 4'd2;
        step();
        check("regrant_gnt", 32'(gnt), 32'd1);
        repeat (4) step();
        req = 2'b00;
        repeat (2) step();

        // Random traffic: requests tend to persist, and resets are occasional.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) len0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) len1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) async_reset_pulse();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter and interval-length width in bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port req, input, 2 bits: req[i] high means requester i wants a timed interval.
REQ-005 Port len0, input, WIDTH bits: interval length requested by requester 0.
REQ-006 Port len1, input, WIDTH bits: interval length requested by requester 1.
REQ-007 Port gnt, output, 2 bits: one-hot grant, registered; high for the requester currently owning the counter.
REQ-008 Port busy, output, 1 bit: high in RUN and DONE states.
REQ-009 Port cnt, output, WIDTH bits: value of the shared interval counter.
REQ-010 Port done, output, 2 bits: done[i] is a one-cycle completion pulse for requester i.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with req == 0, the block SHALL hold: gnt = 0, cnt unchanged, ptr unchanged.
REQ-013 In IDLE with exactly one req bit high, that requester SHALL be granted.
REQ-014 In IDLE with both req bits high, the requester indexed by the round-robin pointer ptr SHALL be granted.
REQ-015 A grant SHALL apply on the next edge: gnt one-hot, cnt = 0, state = RUN, and len_q = the granted requester's len, latched.
REQ-016 Changes on len0 or len1 after the grant edge SHALL have no effect until the next grant.
REQ-017 In RUN with cnt != len_q and the owner's req still high, cnt SHALL increment by 1.
REQ-018 In RUN with cnt == len_q and the owner's req still high, the next state SHALL be DONE and cnt SHALL hold.
REQ-019 In DONE, done[owner] SHALL be 1 for exactly that cycle and gnt SHALL be 0.
REQ-020 From DONE, the next state SHALL be IDLE and ptr SHALL be set to the index of the other requester.
REQ-021 Latency: with the first RUN cycle as G, cnt SHALL equal k in cycle G+k, and done SHALL pulse in cycle G+len_q+1.
REQ-022 Interval occupancy SHALL be len_q+1 RUN cycles, one DONE cycle, then at least one IDLE cycle before the next grant.
REQ-023 len = 0 SHALL give one RUN cycle with cnt = 0, followed by DONE.
REQ-024 len = 2^WIDTH-1 SHALL reach all-ones with no wrap-around; cnt SHALL never wrap.
REQ-025 If the owner's req falls in RUN, the next state SHALL be IDLE with gnt = 0 and no done pulse (abort).
REQ-026 On abort, cnt SHALL hold and ptr SHALL be set to the other requester.
REQ-027 The non-owner's req SHALL be ignored outside IDLE; it is served on a later IDLE cycle if still high.
REQ-028 gnt and done SHALL never have more than one bit high.
REQ-029 done SHALL never be high in the same cycle as any gnt bit.

Reset
REQ-030 While reset = 1, the block SHALL force state = IDLE, gnt = 0, done = 0, busy = 0, cnt = 0, ptr = 0, len_q = 0, regardless of clk.
REQ-031 reset asserted mid-RUN or mid-DONE SHALL cancel the interval immediately and produce no done pulse.
REQ-032 After reset deasserts, the first grant SHALL be evaluated on the first rising clk edge.

Verification
REQ-033 Single request: req = 01, len0 = 3 -> gnt = 01 for 4 cycles with cnt 0,1,2,3; done = 01 in the next cycle; then IDLE.
REQ-034 Contention: req = 11 held, len0 = 1, len1 = 2 after reset -> requester 0 served first, then requester 1, then requester 0 again, with done alternating 01, 10, 01.
REQ-035 Boundaries: len1 = 0 -> one RUN cycle then done = 10; len0 = 15 -> cnt reaches 15, done = 01, and no wrap is observed.
REQ-036 Abort: req = 01, len0 = 8, req0 dropped when cnt = 4 -> gnt = 00 next cycle, no done, and ptr points to requester 1.
REQ-037 Async reset: reset pulsed between clock edges with cnt = 5 in RUN -> all outputs 0 immediately, no done pulse, and normal re-grant after release.
REQ-038 Latch check: len0 changed from 3 to 9 during RUN -> interval still ends with cnt = 3.
